// File: rtl/gpr_sb.sv
// rtl/gpr_sb.sv - register file with dual write ports, bypass and RAW scoreboard
module gpr_sb #(
  parameter int WIDTH  = 10,
  parameter int DEPTH  = 10,
  parameter int AW     = 4,
  parameter int NRD    = 4,
  parameter int BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write0,
  input  logic                   write1,
  input  logic [AW-1:0]          inaddr0,
  input  logic [AW-1:0]          inaddr1,
  input  logic [WIDTH-1:0]       indata0,
  input  logic [WIDTH-1:0]       indata1,
  input  logic [NRD-1:0]         read,
  input  logic [NRD*AW-1:0]      outaddr,
  output logic [NRD*WIDTH-1:0]   outdata,
  output logic [NRD-1:0]         hazard,
  input  logic                   reserve,
  input  logic [AW-1:0]          resaddr,
  output logic                   res_ok,
  output logic [DEPTH-1:0]       busy,
  output logic                   err,
  output logic [DEPTH*WIDTH-1:0] dump
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  // Address decodes compare against DEPTH with one extra bit so DEPTH = 2^AW works.
  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic             err_q;

  // Valid (in-range) write requests; port 1 is suppressed when it collides with port 0.
  logic v0, v1, we0, we1;
  assign v0  = write0 & in_range(inaddr0);
  assign v1  = write1 & in_range(inaddr1);
  assign we1 = v1 & ~(v0 && (inaddr1 == inaddr0));
  assign we0 = v0;

  logic [AW-1:0]    rd_addr [NRD];
  logic [WIDTH-1:0] rd_val  [NRD];
  logic [NRD-1:0]   rd_busy;
  logic [NRD-1:0]   rd_bad;
  logic [NRD-1:0]   byp0;
  logic [NRD-1:0]   byp1;
  logic [NRD-1:0]   haz;

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      assign rd_addr[gi] = outaddr[gi*AW +: AW];
      // Disabled ports release their slice so several readers can share a bus.
      assign outdata[gi*WIDTH +: WIDTH] = read[gi] ? rd_val[gi] : {WIDTH{1'bz}};
    end
  endgenerate

  // Read ports: register mux, write forwarding and hazard detection.
  always_comb begin
    rd_busy = '0;
    rd_bad  = '0;
    byp0    = '0;
    byp1    = '0;
    haz     = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_val[i] = '0;
      if (in_range(rd_addr[i])) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (rd_addr[i] == AW'(k)) begin
            rd_val[i]  = regs[k];
            rd_busy[i] = busy_q[k];
          end
        end
        byp0[i] = (BYPASS != 0) && v0 && (inaddr0 == rd_addr[i]);
        byp1[i] = (BYPASS != 0) && v1 && (inaddr1 == rd_addr[i]);
        if (byp0[i]) begin
          rd_val[i] = indata0;
        end else if (byp1[i]) begin
          rd_val[i] = indata1;
        end
      end else begin
        rd_bad[i] = read[i];
      end
      haz[i] = read[i] & rd_busy[i] & ~(byp0[i] | byp1[i]);
    end
  end

  assign hazard = haz;

  // Reservation check: a busy register may be re-reserved only when its writeback lands now.
  logic res_busy;
  logic res_hit;
  always_comb begin
    res_busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (resaddr == AW'(k)) res_busy = busy_q[k];
    end
  end

  assign res_hit = (v0 && (inaddr0 == resaddr)) || (v1 && (inaddr1 == resaddr));
  assign res_ok  = reserve & in_range(resaddr) & (~res_busy | res_hit);

  logic err_set;
  assign err_set = (write0 & ~in_range(inaddr0)) |
                   (write1 & ~in_range(inaddr1)) |
                   (reserve & ~in_range(resaddr)) |
                   (|rd_bad);

  // Register storage: port 0 wins a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (we0 && (inaddr0 == AW'(k))) begin
          regs[k] <= indata0;
        end else if (we1 && (inaddr1 == AW'(k))) begin
          regs[k] <= indata1;
        end
      end
    end
  end

  // Scoreboard: writeback clears, an accepted reservation sets and takes precedence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (res_ok && (resaddr == AW'(k))) begin
          busy_q[k] <= 1'b1;
        end else if ((v0 && (inaddr0 == AW'(k))) || (v1 && (inaddr1 == AW'(k)))) begin
          busy_q[k] <= 1'b0;
        end
      end
    end
  end

  // Sticky out-of-range address flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign busy = busy_q;
  assign err  = err_q;

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_dump
      assign dump[gi*WIDTH +: WIDTH] = regs[gi];
    end
  endgenerate

endmodule

// File: tb/tb_gpr_sb.sv
// tb/tb_gpr_sb.sv - scoreboard bench for gpr_sb (bypass and non-bypass instances)
module tb_gpr_sb;

  logic         clk = 1'b0;
  logic         rst;
  logic         write0, write1;
  logic [3:0]   inaddr0, inaddr1;
  logic [9:0]   indata0, indata1;
  logic [3:0]   read;
  logic [15:0]  outaddr;
  logic         reserve;
  logic [3:0]   resaddr;

  logic [39:0]  outdata, outdata_b;
  logic [3:0]   hazard, hazard_b;
  logic         res_ok, res_ok_b;
  logic [9:0]   busy, busy_b;
  logic         err, err_b;
  logic [99:0]  dump, dump_b;

  gpr_sb #(.WIDTH(10), .DEPTH(10), .AW(4), .NRD(4), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .write0(write0), .write1(write1),
    .inaddr0(inaddr0), .inaddr1(inaddr1), .indata0(indata0), .indata1(indata1),
    .read(read), .outaddr(outaddr), .outdata(outdata), .hazard(hazard),
    .reserve(reserve), .resaddr(resaddr), .res_ok(res_ok), .busy(busy),
    .err(err), .dump(dump)
  );

  gpr_sb #(.WIDTH(10), .DEPTH(10), .AW(4), .NRD(4), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .write0(write0), .write1(write1),
    .inaddr0(inaddr0), .inaddr1(inaddr1), .indata0(indata0), .indata1(indata1),
    .read(read), .outaddr(outaddr), .outdata(outdata_b), .hazard(hazard_b),
    .reserve(reserve), .resaddr(resaddr), .res_ok(res_ok_b), .busy(busy_b),
    .err(err_b), .dump(dump_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    int           sel;
    logic [127:0] exp;
    logic [127:0] mask;
  } chk_t;

  chk_t sb_q[$];
  int   tests  = 0;
  int   failed = 0;
  event sample_ev;
  logic [9:0] m [10];

  localparam logic [127:0] ALL = {128{1'b1}};
  localparam logic [127:0] P0  = 128'h3FF;

  function automatic logic [127:0] get_act(input int sel);
    case (sel)
      0:  return {28'b0, dump};
      1:  return {118'b0, busy};
      2:  return {127'b0, err};
      3:  return {127'b0, res_ok};
      4:  return {124'b0, hazard};
      5:  return {88'b0, outdata};
      6:  return {88'b0, outdata_b};
      7:  return {124'b0, hazard_b};
      8:  return {28'b0, dump_b};
      9:  return {118'b0, busy_b};
      10: return {127'b0, err_b};
      default: return {127'b0, res_ok_b};
    endcase
  endfunction

  function automatic logic [127:0] model_dump();
    logic [127:0] r = '0;
    for (int k = 0; k < 10; k++) r[k*10 +: 10] = m[k];
    return r;
  endfunction

  function automatic logic [127:0] pk(input logic [9:0] a, input logic [9:0] b,
                                      input logic [9:0] c, input logic [9:0] d);
    return {88'b0, d, c, b, a};
  endfunction

  task automatic expect_v(input string name, input int sel, input logic [127:0] exp,
                          input logic [127:0] mask);
    chk_t c;
    c.name = name; c.sel = sel; c.exp = exp; c.mask = mask;
    sb_q.push_back(c);
  endtask

  // Monitor: drains the scoreboard whenever a sample point is announced.
  initial begin
    chk_t c;
    logic [127:0] act;
    forever begin
      @(sample_ev);
      while (sb_q.size() > 0) begin
        c = sb_q.pop_front();
        act = get_act(c.sel) & c.mask;
        tests++;
        if (act !== (c.exp & c.mask)) begin
          failed++;
          $display("FAIL %s: got %h expected %h", c.name, act, c.exp & c.mask);
        end
      end
    end
  end

  task automatic check();
    -> sample_ev;
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) #1;
    if (sb_q.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL sb_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic clr();
    write0 = 0; write1 = 0; inaddr0 = 0; inaddr1 = 0; indata0 = 0; indata1 = 0;
    read = 0; outaddr = 0; reserve = 0; resaddr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
    #1;
  endtask

  initial begin
    for (int k = 0; k < 10; k++) m[k] = '0;
    clr();
    rst = 1'b1;
    #12 rst = 1'b0;
    #1;
    expect_v("rst_dump", 0, '0, ALL);
    expect_v("rst_busy", 1, '0, ALL);
    expect_v("rst_err", 2, '0, ALL);
    expect_v("rst_res_ok", 3, '0, ALL);
    expect_v("rst_hazard", 4, '0, ALL);
    expect_v("rst_dump_nb", 8, '0, ALL);
    expect_v("rst_busy_nb", 9, '0, ALL);
    expect_v("rst_err_nb", 10, '0, ALL);
    expect_v("rst_res_ok_nb", 11, '0, ALL);
    check();

    // Dual write to different registers, reservation and range read, then async reset
    @(posedge clk); #1;
    write0 = 1; inaddr0 = 3; indata0 = 10'h2A5;
    write1 = 1; inaddr1 = 9; indata1 = 10'h155;
    reserve = 1; resaddr = 4;
    read = 4'b0001; outaddr = 16'h000C;
    #1;
    expect_v("res_ok_r4", 3, 1, ALL);
    expect_v("rd_range_zero", 5, '0, P0);
    check();
    tick();
    m[3] = 10'h2A5; m[9] = 10'h155;
    expect_v("dump_r3_r9", 0, model_dump(), ALL);
    expect_v("busy_r4", 1, 128'h010, ALL);
    expect_v("err_set_read", 2, 1, ALL);
    check();
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) m[k] = '0;
    expect_v("async_rst_dump", 0, '0, ALL);
    expect_v("async_rst_busy", 1, '0, ALL);
    expect_v("async_rst_err", 2, '0, ALL);
    check();
    rst = 1'b0;

    // Collision: port 0 wins
    @(posedge clk); #1;
    write0 = 1; inaddr0 = 5; indata0 = 10'h111;
    write1 = 1; inaddr1 = 5; indata1 = 10'h222;
    tick();
    m[5] = 10'h111;
    expect_v("collision_r5", 0, model_dump(), ALL);
    check();
    write0 = 1; inaddr0 = 1; indata0 = 10'h3FF;
    write1 = 1; inaddr1 = 2; indata1 = 10'h001;
    tick();
    m[1] = 10'h3FF; m[2] = 10'h001;
    expect_v("dual_r1_r2", 0, model_dump(), ALL);
    check();

    // Bypass on all four ports
    write0 = 1; inaddr0 = 4; indata0 = 10'h0AB;
    read = 4'hF; outaddr = 16'h4444;
    #1;
    expect_v("bypass_all", 5, pk(10'h0AB, 10'h0AB, 10'h0AB, 10'h0AB), ALL);
    expect_v("nobypass_old", 6, pk(0, 0, 0, 0), ALL);
    expect_v("bypass_hazard", 4, '0, ALL);
    check();
    tick();
    m[4] = 10'h0AB;
    read = 4'hF; outaddr = 16'h4444;
    #1;
    expect_v("nobypass_after", 6, pk(10'h0AB, 10'h0AB, 10'h0AB, 10'h0AB), ALL);
    expect_v("dump_nb_r4", 8, model_dump(), ALL);
    check();
    clr();

    // Scoreboard RAW
    reserve = 1; resaddr = 7;
    #1;
    expect_v("res_ok_r7", 3, 1, ALL);
    check();
    tick();
    expect_v("busy_r7", 1, 128'h080, ALL);
    check();
    read = 4'b0001; outaddr = 16'h0007;
    #1;
    expect_v("hazard_r7", 4, 128'h1, ALL);
    expect_v("hazard_r7_nb", 7, 128'h1, ALL);
    check();
    write0 = 1; inaddr0 = 7; indata0 = 10'h07F;
    #1;
    expect_v("hazard_bypassed", 4, '0, ALL);
    expect_v("hazard_nb_kept", 7, 128'h1, ALL);
    expect_v("bypass_r7", 5, 128'h07F, P0);
    check();
    tick();
    m[7] = 10'h07F;
    expect_v("busy_cleared", 1, '0, ALL);
    expect_v("dump_r7", 0, model_dump(), ALL);
    check();

    // Reservation conflict
    reserve = 1; resaddr = 7;
    tick();
    expect_v("busy_r7_again", 1, 128'h080, ALL);
    check();
    reserve = 1; resaddr = 7;
    #1;
    expect_v("res_conflict", 3, '0, ALL);
    check();
    tick();
    expect_v("conflict_busy", 1, 128'h080, ALL);
    expect_v("conflict_dump", 0, model_dump(), ALL);
    check();
    reserve = 1; resaddr = 7;
    write0 = 1; inaddr0 = 7; indata0 = 10'h001;
    #1;
    expect_v("res_with_write", 3, 1, ALL);
    check();
    tick();
    m[7] = 10'h001;
    expect_v("res_wins_busy", 1, 128'h080, ALL);
    expect_v("res_wins_dump", 0, model_dump(), ALL);
    check();

    // Range error
    expect_v("err_clear", 2, '0, ALL);
    check();
    read = 4'b0001; outaddr = 16'h000C;
    #1;
    expect_v("rd_r12_zero", 5, '0, P0);
    expect_v("rd_r12_zero_nb", 6, '0, P0);
    check();
    tick();
    expect_v("err_after_read", 2, 1, ALL);
    check();
    write0 = 1; inaddr0 = 15; indata0 = 10'h3FF;
    tick();
    expect_v("oob_write_dump", 0, model_dump(), ALL);
    expect_v("oob_write_err", 2, 1, ALL);
    check();
    repeat (3) @(posedge clk);
    #1;
    expect_v("err_sticky", 2, 1, ALL);
    expect_v("err_sticky_nb", 10, 1, ALL);
    check();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) m[k] = '0;
    expect_v("final_rst_err", 2, '0, ALL);
    expect_v("final_rst_busy", 1, '0, ALL);
    expect_v("final_rst_dump", 0, model_dump(), ALL);
    check();
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
